// File: rtl/uart_rx_arb_pkg.sv
// Shared types and helpers for the UART RX channel arbiter.
// Grant search helper is sized for the largest supported channel count (16)
// so one function serves every NCH instance.
package uart_rx_arb_pkg;

  // Arbitration mode as carried on the mode input
  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int MAX_NCH  = 16;
  localparam int MAX_SELW = 4;

  // Rotate-priority search: starting at last+1 (mod nch), return the index of
  // the first channel with valid set, or -1 when no channel is requesting.
  // nch must be a power of two so the wrap is a simple mask.
  function automatic int rr_pick(
    input logic [MAX_NCH-1:0] valid,
    input int                 last,
    input int                 nch
  );
    int pick;
    int idx;
    pick = -1;
    for (int i = 1; i <= MAX_NCH; i++) begin
      idx = (last + i) & (nch - 1);
      if ((pick < 0) && (i <= nch) && valid[idx[MAX_SELW-1:0]]) begin
        pick = idx;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/uart_rx_arb_fifo.sv
// Circular output FIFO for the UART RX arbiter.
// Push and pop may happen in the same cycle, including when full; the caller
// only pushes when there is room or a pop is happening. dout_o reads as zero
// while empty so no stale entry is ever visible on the output.
module uart_rx_arb_fifo #(
  parameter int EW    = 11,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [EW-1:0] din_i,
  output logic [EW-1:0] dout_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [EW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
  end

  // Pointer and occupancy registers; reset empties the FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are only meaningful between the pointers
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == (AW+1)'(0));
  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_rx_chan_arb.sv
// N-channel UART RX byte arbiter: grants one channel per cycle (fixed select
// or round-robin) into a registered ready/valid output tagged with the source
// channel.
// Build option: define UART_RX_ARB_FIFO_EN to replace the single output
// register with a DEPTH-entry FIFO; the port list is the same either way.
module uart_rx_chan_arb
  import uart_rx_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NCH   = 8,
  parameter int SELW  = $clog2(NCH),
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  input  logic [NCH-1:0]     in_valid,
  input  logic [NCH*WIDTH-1:0] in_data,
  output logic [NCH-1:0]     in_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_ch,
  input  logic               out_ready
);

  logic [NCH-1:0]   grant_s;
  logic [SELW-1:0]  win_idx_s;
  logic [WIDTH-1:0] win_data_s;
  logic             accept_s;
  logic             pop_s;
  logic             space_s;
  int               rr_pick_s;
  logic [SELW-1:0]  last_q, last_d;

  // Grant selection; nothing is granted while in reset or when the output
  // stage cannot take a byte this cycle
  always_comb begin
    grant_s   = '0;
    rr_pick_s = rr_pick(MAX_NCH'(in_valid), int'(last_q), NCH);
    if (!rst_n || !space_s) begin
      grant_s = '0;
    end else begin
      case (arb_mode_e'(mode))
        ARB_FIXED: grant_s[sel] = in_valid[sel];
        ARB_RR: begin
          for (int k = 0; k < NCH; k++) begin
            grant_s[k] = (rr_pick_s == k);
          end
        end
        default: grant_s = '0;
      endcase
    end
  end

  // One-hot grant to channel index and the byte it carries
  always_comb begin
    win_idx_s = '0;
    for (int k = 0; k < NCH; k++) begin
      win_idx_s = grant_s[k] ? SELW'(k) : win_idx_s;
    end
    win_data_s = in_data[win_idx_s*WIDTH +: WIDTH];
  end

  assign accept_s = |grant_s;
  assign in_ready = grant_s;

  // Round-robin pointer follows every accepted byte, whatever the mode
  always_comb begin
    last_d = accept_s ? win_idx_s : last_q;
  end

  // Round-robin pointer register; reset value lets channel 0 win first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= SELW'(NCH - 1);
    end else begin
      last_q <= last_d;
    end
  end

`ifdef UART_RX_ARB_FIFO_EN

  logic [SELW+WIDTH-1:0] fifo_dout_s;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;

  // A full FIFO still accepts when the head leaves in the same cycle
  assign pop_s   = ~fifo_empty_s & out_ready;
  assign space_s = ~fifo_full_s | pop_s;

  uart_rx_arb_fifo #(
    .EW    (SELW + WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept_s),
    .pop_i   (pop_s),
    .din_i   ({win_idx_s, win_data_s}),
    .dout_o  (fifo_dout_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  assign out_valid = ~fifo_empty_s;
  assign out_ch    = fifo_dout_s[SELW+WIDTH-1:WIDTH];
  assign out_data  = fifo_dout_s[WIDTH-1:0];

`else

  logic             out_vld_q, out_vld_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_ch_q, out_ch_d;

  // Single slot: free when empty or when its byte is leaving this cycle
  assign pop_s   = out_vld_q & out_ready;
  assign space_s = ~out_vld_q | out_ready;

  // Output slot next-state: load on grant, clear on drain, otherwise hold
  // so data and tag stay stable under backpressure
  always_comb begin
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    if (accept_s) begin
      out_vld_d  = 1'b1;
      out_data_d = win_data_s;
      out_ch_d   = win_idx_s;
    end else if (pop_s) begin
      out_vld_d  = 1'b0;
    end else begin
      out_vld_d  = out_vld_q;
    end
  end

  // Output slot registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_data_q <= '0;
      out_ch_q   <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
    end
  end

  assign out_valid = out_vld_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

`endif

endmodule

// File: tb/tb_uart_rx_chan_arb.sv
// Self-checking bench for uart_rx_chan_arb (NCH=8, WIDTH=8).
// Works for both output-stage builds; CAP is the output-stage capacity.
module tb_uart_rx_chan_arb;

`ifdef UART_RX_ARB_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic [2:0]  sel;
  logic [7:0]  in_valid;
  logic [63:0] in_data;
  logic [7:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [2:0]  out_ch;
  logic        out_ready;

  int total = 0;
  int bad   = 0;

  uart_rx_chan_arb #(.WIDTH(8), .NCH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Reference model: queue of {channel, byte} in grant order plus last grant
  logic [10:0] mq [$];
  int          m_last;
  int          gch_g;
  bit          pop_g;
  logic [7:0]  exp_rdy_g;
  logic [63:0] d_g;

  typedef struct {
    logic       m;
    logic [2:0] s;
    logic [7:0] v;
    logic       r;
    logic [7:0] e_rdy;
    logic       e_vld;
    logic [2:0] e_ch;
  } vec_t;
  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] pat();
    logic [63:0] p;
    for (int k = 0; k < 8; k++) p[k*8 +: 8] = 8'hA0 + 8'(k);
    return p;
  endfunction

  // Apply inputs on the falling edge and predict this cycle's grant
  task automatic drive(input logic m, input logic [2:0] s, input logic [7:0] v,
                       input logic r, input logic [63:0] d);
    int c;
    bit space;
    @(negedge clk);
    mode = m; sel = s; in_valid = v; out_ready = r; in_data = d;
    #1;
    pop_g = (mq.size() > 0) && r;
    space = (mq.size() < CAP) || pop_g;
    gch_g = -1;
    if (space) begin
      if (!m) begin
        if (v[s]) gch_g = int'(s);
      end else begin
        for (int i = 1; i <= 8; i++) begin
          c = (m_last + i) % 8;
          if (gch_g < 0 && v[c[2:0]]) gch_g = c;
        end
      end
    end
    exp_rdy_g = (gch_g >= 0) ? (8'd1 << gch_g) : 8'd0;
    d_g = d;
  endtask

  task automatic mcheck();
    chk("m_ready", 32'(in_ready), 32'(exp_rdy_g));
    chk("m_valid", 32'(out_valid), 32'(mq.size() > 0));
    if (mq.size() > 0) chk("m_entry", 32'({out_ch, out_data}), 32'(mq[0]));
  endtask

  task automatic tick();
    @(posedge clk);
    if (pop_g) void'(mq.pop_front());
    if (gch_g >= 0) begin
      mq.push_back({gch_g[2:0], d_g[gch_g*8 +: 8]});
      m_last = gch_g;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 8'h00;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    mq.delete();
    m_last = 7;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] e8;
    int g;
    tbl[0]  = '{1'b0, 3'd5, 8'h21, 1'b1, 8'h20, 1'b0, 3'd0};
    tbl[1]  = '{1'b0, 3'd5, 8'h21, 1'b1, 8'h20, 1'b1, 3'd5};
    tbl[2]  = '{1'b0, 3'd5, 8'h01, 1'b1, 8'h00, 1'b1, 3'd5};
    tbl[3]  = '{1'b1, 3'd5, 8'h01, 1'b1, 8'h01, 1'b0, 3'd0};
    tbl[4]  = '{1'b1, 3'd5, 8'h0C, 1'b1, 8'h04, 1'b1, 3'd0};
    tbl[5]  = '{1'b1, 3'd5, 8'h0C, 1'b1, 8'h08, 1'b1, 3'd2};
    tbl[6]  = '{1'b1, 3'd5, 8'h88, 1'b1, 8'h80, 1'b1, 3'd3};
    tbl[7]  = '{1'b1, 3'd5, 8'h88, 1'b1, 8'h08, 1'b1, 3'd7};
    tbl[8]  = '{1'b1, 3'd5, 8'h00, 1'b1, 8'h00, 1'b1, 3'd3};
    tbl[9]  = '{1'b0, 3'd3, 8'hFF, 1'b1, 8'h08, 1'b0, 3'd0};
    tbl[10] = '{1'b0, 3'd3, 8'hFF, 1'b1, 8'h08, 1'b1, 3'd3};

    rst_n = 1'b0; mode = 1'b1; sel = 3'd0; in_valid = 8'hFF;
    in_data = pat(); out_ready = 1'b1; m_last = 7;
    #12;
    chk("rst_ready", 32'(in_ready), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_ch", 32'(out_ch), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // Round-robin sweep from reset, one byte per cycle
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 3'd0, 8'hFF, 1'b1, pat());
      chk("rr_ready", 32'(in_ready), 32'(8'd1 << (i % 8)));
      chk("rr_valid", 32'(out_valid), 32'(i > 0));
      if (i > 0) chk("rr_ch", 32'(out_ch), 32'((i - 1) % 8));
      tick();
    end

    // Table-driven vectors from a fresh reset
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].m, tbl[i].s, tbl[i].v, tbl[i].r, pat());
      chk("tbl_ready", 32'(in_ready), 32'(tbl[i].e_rdy));
      chk("tbl_valid", 32'(out_valid), 32'(tbl[i].e_vld));
      if (tbl[i].e_vld) begin
        chk("tbl_ch", 32'(out_ch), 32'(tbl[i].e_ch));
        chk("tbl_data", 32'(out_data), 32'(8'hA0 | {5'd0, tbl[i].e_ch}));
      end
      tick();
    end

    // Backpressure with channels 2 and 3, then drain
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 3'd0, 8'h0C, 1'b0, pat());
      e8 = (i < CAP) ? ((i % 2 == 0) ? 8'h04 : 8'h08) : 8'h00;
      chk("bp_ready", 32'(in_ready), 32'(e8));
      chk("bp_valid", 32'(out_valid), 32'(i > 0));
      if (i > 0) begin
        chk("bp_ch", 32'(out_ch), 32'd2);
        chk("bp_data", 32'(out_data), 32'hA2);
      end
      tick();
    end
    g = (CAP < 6) ? CAP : 6;
    for (int j = 0; j < 4; j++) begin
      drive(1'b1, 3'd0, 8'h0C, 1'b1, pat());
      chk("drain_ch", 32'(out_ch), (j % 2 == 0) ? 32'd2 : 32'd3);
      chk("drain_valid", 32'(out_valid), 32'd1);
      if (j == 0) chk("full_push", 32'(in_ready), (g % 2 == 1) ? 32'h08 : 32'h04);
      mcheck();
      tick();
    end

    // Mode switch with a byte buffered
    do_reset();
    drive(1'b1, 3'd0, 8'h02, 1'b0, pat());
    chk("sw_ready0", 32'(in_ready), 32'h02);
    tick();
    drive(1'b0, 3'd6, 8'h42, 1'b0, pat());
    chk("sw_ready1", 32'(in_ready), (CAP > 1) ? 32'h40 : 32'h00);
    chk("sw_hold", 32'({out_ch, out_data}), 32'({3'd1, 8'hA1}));
    tick();
    drive(1'b0, 3'd6, 8'h42, 1'b1, pat());
    chk("sw_ready2", 32'(in_ready), 32'h40);
    chk("sw_deliver", 32'({out_ch, out_data}), 32'({3'd1, 8'hA1}));
    tick();
    drive(1'b0, 3'd6, 8'h00, 1'b1, pat());
    chk("sw_next", 32'({out_valid, out_ch, out_data}), 32'({1'b1, 3'd6, 8'hA6}));
    tick();

    // Reset in the middle of a stream
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd0, 8'h0C, 1'b0, pat());
      tick();
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    in_valid = 8'hFF;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_ready", 32'(in_ready), 32'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    mq.delete();
    m_last = 7;
    drive(1'b1, 3'd0, 8'hFF, 1'b1, pat());
    chk("post_rst_ready", 32'(in_ready), 32'h01);
    chk("post_rst_valid", 32'(out_valid), 32'h0);
    tick();
    drive(1'b1, 3'd0, 8'h00, 1'b1, pat());
    chk("post_rst_first", 32'({out_valid, out_ch, out_data}), 32'({1'b1, 3'd0, 8'hA0}));
    tick();
    drive(1'b1, 3'd0, 8'h00, 1'b1, pat());
    chk("post_rst_empty", 32'(out_valid), 32'h0);
    tick();

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            8'($urandom) & 8'($urandom), 1'($urandom_range(0, 3) != 0),
            {$urandom, $urandom});
      mcheck();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
